// File: rtl/comp_arbiter.sv
// Round-robin arbiter sharing one external comparator between NREQ requesters.
// Optional COMP_ARB_CHECK_EN adds cmp_err, flagging non-one-hot comparator results.
module comp_arbiter #(
    parameter int unsigned DATAWIDTH = 8,
    parameter int unsigned NREQ      = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*DATAWIDTH-1:0] a_in,
    input  logic [NREQ*DATAWIDTH-1:0] b_in,
    output logic [NREQ-1:0]           gnt,
    output logic [NREQ-1:0]           rsp_valid,
    output logic                      rsp_gt,
    output logic                      rsp_lt,
    output logic                      rsp_eq,
    output logic [DATAWIDTH-1:0]      cmp_a,
    output logic [DATAWIDTH-1:0]      cmp_b,
    input  logic                      cmp_gt,
    input  logic                      cmp_lt,
    input  logic                      cmp_eq
`ifdef COMP_ARB_CHECK_EN
    ,
    output logic                      cmp_err
`endif
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EVAL = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]           state;
    logic [1:0]           state_d;
    logic [PTR_W-1:0]     ptr;
    logic [PTR_W-1:0]     ptr_d;
    logic [PTR_W-1:0]     win;
    logic [PTR_W-1:0]     win_d;
    logic [PTR_W-1:0]     pick;
    logic                 found;
    logic [DATAWIDTH-1:0] a_sel;
    logic [DATAWIDTH-1:0] b_sel;
    logic [NREQ-1:0]      gnt_d;
    logic [NREQ-1:0]      rsp_valid_d;
    logic                 cap_ops;
    logic                 cap_flags;

    // First requester at or above ptr, wrapping modulo NREQ
    always_comb begin : pick_blk
        int unsigned idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req[PTR_W'(idx)]) begin
                found = 1'b1;
                pick  = PTR_W'(idx);
            end
        end
    end

    // Operand select for the candidate winner
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (pick == PTR_W'(j)) begin
                a_sel = a_in[j*DATAWIDTH +: DATAWIDTH];
                b_sel = b_in[j*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

    // Next-state and registered-output decode
    always_comb begin
        state_d     = state;
        ptr_d       = ptr;
        win_d       = win;
        gnt_d       = '0;
        rsp_valid_d = '0;
        cap_ops     = 1'b0;
        cap_flags   = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_d   = NREQ'(1) << pick;
                    win_d   = pick;
                    cap_ops = 1'b1;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                rsp_valid_d = NREQ'(1) << win;
                cap_flags   = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                ptr_d   = (win == PTR_W'(NREQ - 1)) ? '0 : win + PTR_W'(1);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            win   <= '0;
        end else begin
            state <= state_d;
            ptr   <= ptr_d;
            win   <= win_d;
        end
    end

    // Output and operand/result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_gt    <= 1'b0;
            rsp_lt    <= 1'b0;
            rsp_eq    <= 1'b0;
            cmp_a     <= '0;
            cmp_b     <= '0;
        end else begin
            gnt       <= gnt_d;
            rsp_valid <= rsp_valid_d;
            if (cap_ops) begin
                cmp_a <= a_sel;
                cmp_b <= b_sel;
            end
            if (cap_flags) begin
                rsp_gt <= cmp_gt;
                rsp_lt <= cmp_lt;
                rsp_eq <= cmp_eq;
            end
        end
    end

`ifdef COMP_ARB_CHECK_EN
    logic flags_onehot;

    assign flags_onehot = ({cmp_gt, cmp_lt, cmp_eq} == 3'b100) ||
                          ({cmp_gt, cmp_lt, cmp_eq} == 3'b010) ||
                          ({cmp_gt, cmp_lt, cmp_eq} == 3'b001);

    // Error pulse aligned with rsp_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_err <= 1'b0;
        end else begin
            cmp_err <= cap_flags && !flags_onehot;
        end
    end
`endif

endmodule

// File: tb/tb_comp_arbiter.sv
// Self-checking bench for comp_arbiter: transaction-level timing model, directed cases,
// then randomized traffic with occasional resets.
module tb_comp_arbiter;

    localparam int unsigned DW = 8;
    localparam int unsigned N  = 4;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*DW-1:0] a_in;
    logic [N*DW-1:0] b_in;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rsp_valid;
    logic            rsp_gt;
    logic            rsp_lt;
    logic            rsp_eq;
    logic [DW-1:0]   cmp_a;
    logic [DW-1:0]   cmp_b;
    logic            cmp_gt;
    logic            cmp_lt;
    logic            cmp_eq;
    logic            force_bad;
`ifdef COMP_ARB_CHECK_EN
    logic            cmp_err;
`endif

    comp_arbiter #(.DATAWIDTH(DW), .NREQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_gt    (rsp_gt),
        .rsp_lt    (rsp_lt),
        .rsp_eq    (rsp_eq),
        .cmp_a     (cmp_a),
        .cmp_b     (cmp_b),
        .cmp_gt    (cmp_gt),
        .cmp_lt    (cmp_lt),
        .cmp_eq    (cmp_eq)
`ifdef COMP_ARB_CHECK_EN
        ,
        .cmp_err   (cmp_err)
`endif
    );

    // External comparator, with an override producing illegal flags
    assign cmp_gt = force_bad ? 1'b1 : (cmp_a > cmp_b);
    assign cmp_lt = force_bad ? 1'b0 : (cmp_a < cmp_b);
    assign cmp_eq = force_bad ? 1'b1 : (cmp_a == cmp_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: timestamps of the pending response and of the next edge a request may be taken
    int            cyc    = 0;
    int            t_rsp  = -1;
    int            t_free = 0;
    int            m_ptr  = 0;
    int            m_w    = 0;
    logic [N-1:0]  e_gnt  = '0;
    logic [N-1:0]  e_rv   = '0;
    logic [2:0]    e_flags = '0;
    logic [DW-1:0] e_a    = '0;
    logic [DW-1:0] e_b    = '0;
`ifdef COMP_ARB_CHECK_EN
    logic          e_err  = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic model_edge();
        int w;
        bit hit;
        if (!rst_n) begin
            e_gnt   = '0;
            e_rv    = '0;
            e_flags = '0;
            e_a     = '0;
            e_b     = '0;
            m_ptr   = 0;
            t_rsp   = -1;
            t_free  = 0;
`ifdef COMP_ARB_CHECK_EN
            e_err   = 1'b0;
`endif
        end else begin
            e_gnt = '0;
            e_rv  = '0;
`ifdef COMP_ARB_CHECK_EN
            e_err = 1'b0;
`endif
            if (cyc == t_rsp) begin
                e_rv[m_w] = 1'b1;
                e_flags   = force_bad ? 3'b101 : {e_a > e_b, e_a < e_b, e_a == e_b};
`ifdef COMP_ARB_CHECK_EN
                e_err     = force_bad;
`endif
            end
            if (cyc >= t_free && req != '0) begin
                hit = 1'b0;
                w   = 0;
                for (int i = 0; i < int'(N); i++) begin
                    if (!hit && req[(m_ptr + i) % int'(N)]) begin
                        hit = 1'b1;
                        w   = (m_ptr + i) % int'(N);
                    end
                end
                e_gnt[w] = 1'b1;
                e_a      = a_in[w*DW +: DW];
                e_b      = b_in[w*DW +: DW];
                m_w      = w;
                m_ptr    = (w + 1) % int'(N);
                t_rsp    = cyc + 1;
                t_free   = cyc + 3;
            end
        end
        cyc++;
    endtask

    // One clock: update model at the edge, compare every output 1 time unit later
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("gnt", 32'(gnt), 32'(e_gnt));
        check("rsp_valid", 32'(rsp_valid), 32'(e_rv));
        check("rsp_flags", 32'({rsp_gt, rsp_lt, rsp_eq}), 32'(e_flags));
        check("cmp_a", 32'(cmp_a), 32'(e_a));
        check("cmp_b", 32'(cmp_b), 32'(e_b));
`ifdef COMP_ARB_CHECK_EN
        check("cmp_err", 32'(cmp_err), 32'(e_err));
`endif
    endtask

    task automatic drop_granted();
        req = req & ~e_gnt;
    endtask

    task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
        a_in[i*DW +: DW] = a;
        b_in[i*DW +: DW] = b;
    endtask

    logic [2:0]    exp3 [4];
    logic [DW-1:0] ra;
    logic [DW-1:0] rb;

    initial begin
        exp3[0] = 3'b010;
        exp3[1] = 3'b001;
        exp3[2] = 3'b100;
        exp3[3] = 3'b010;
        rst_n     = 1'b0;
        req       = 4'b1111;
        a_in      = '0;
        b_in      = '0;
        force_bad = 1'b0;

        // Reset with all requests pending, then the first grant goes to requester 0
        repeat (3) step();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_cmp_a", 32'(cmp_a), 32'h0);
        rst_n = 1'b1;
        step();
        check("first_gnt", 32'(gnt), 32'h1);
        req = '0;
        repeat (3) step();

        // Single requester, a > b
        set_op(0, 8'd20, 8'd10);
        req = 4'b0001;
        step();
        check("t2_gnt", 32'(gnt), 32'h1);
        drop_granted();
        step();
        check("t2_rsp_valid", 32'(rsp_valid), 32'h1);
        check("t2_flags", 32'({rsp_gt, rsp_lt, rsp_eq}), 32'h4);
        step();

        // All requesting: grants rotate 0..3 every three cycles
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        set_op(0, 8'd10, 8'd20);
        set_op(1, 8'd15, 8'd15);
        set_op(2, 8'd20, 8'd10);
        set_op(3, 8'd0, 8'd255);
        req = 4'b1111;
        for (int g = 0; g < 4; g++) begin
            step();
            check("t3_gnt", 32'(gnt), 32'(1) << g);
            drop_granted();
            step();
            check("t3_rsp_valid", 32'(rsp_valid), 32'(1) << g);
            check("t3_flags", 32'({rsp_gt, rsp_lt, rsp_eq}), 32'(exp3[g]));
            step();
        end

        // Pointer after a grant to 2 favours 3 over 0
        set_op(2, 8'd1, 8'd2);
        req = 4'b0100;
        step();
        check("t4_gnt2", 32'(gnt), 32'h4);
        drop_granted();
        repeat (2) step();
        set_op(0, 8'd7, 8'd7);
        set_op(3, 8'd9, 8'd3);
        req = 4'b1001;
        step();
        check("t4_gnt3", 32'(gnt), 32'h8);
        drop_granted();
        repeat (2) step();
        step();
        check("t4_gnt0", 32'(gnt), 32'h1);
        drop_granted();
        repeat (2) step();

        // Reset while evaluating discards the operation and clears the pointer
        set_op(1, 8'd50, 8'd40);
        req = 4'b0010;
        step();
        check("t5_gnt", 32'(gnt), 32'h2);
        rst_n = 1'b0;
        step();
        check("t5_rsp_valid", 32'(rsp_valid), 32'h0);
        check("t5_cmp_a", 32'(cmp_a), 32'h0);
        rst_n = 1'b1;
        req = 4'b1111;
        step();
        check("t5_gnt_after", 32'(gnt), 32'h1);
        req = '0;
        repeat (2) step();

`ifdef COMP_ARB_CHECK_EN
        // Illegal comparator flags raise cmp_err with rsp_valid; legal ones do not
        force_bad = 1'b1;
        req = 4'b0001;
        step();
        drop_granted();
        step();
        check("t6_err", 32'(cmp_err), 32'h1);
        check("t6_flags", 32'({rsp_gt, rsp_lt, rsp_eq}), 32'h5);
        step();
        force_bad = 1'b0;
        req = 4'b0001;
        step();
        drop_granted();
        step();
        check("t6_noerr", 32'(cmp_err), 32'h0);
        step();
`endif

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            step();
            drop_granted();
            for (int i = 0; i < int'(N); i++) begin
                if (!req[i] && !e_gnt[i] && $urandom_range(3) == 0) begin
                    ra = DW'($urandom);
                    rb = ($urandom_range(3) == 0) ? ra : DW'($urandom);
                    set_op(i, ra, rb);
                    req[i] = 1'b1;
                end
            end
            rst_n = ($urandom_range(299) == 0) ? 1'b0 : 1'b1;
`ifdef COMP_ARB_CHECK_EN
            force_bad = ($urandom_range(7) == 0);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
